// File: rtl/srt_div_pkg.sv
// Shared definitions for the radix-2 SRT divider: FSM state encoding, quotient
// digit encoding, digit-selection thresholds and a leading-zero counter.
package srt_div_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD = 3'd1;
  localparam logic [STATE_W-1:0] ST_ITER = 3'd2;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd3;

  localparam int unsigned DIG_W = 2;

  localparam logic [DIG_W-1:0] DIG_ZERO = 2'b00;
  localparam logic [DIG_W-1:0] DIG_POS  = 2'b01;
  localparam logic [DIG_W-1:0] DIG_NEG  = 2'b10;

  // Thresholds on the signed top-3-bit estimate of 2P, in units of 1/2 * 2^WIDTH
  localparam logic signed [2:0] EST_POS_MIN = 3'sb001;
  localparam logic signed [2:0] EST_NEG_MAX = 3'sb110;

  // Leading-zero count of a 32-bit word (32 for zero)
  function automatic logic [5:0] lzc32(input logic [31:0] x);
    logic [5:0] n;
    logic       found;
    n     = 6'd0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (x[i]) begin
        found = 1'b1;
      end else if (!found) begin
        n = n + 6'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/srt_divider_seq_qsel.sv
// Radix-2 SRT quotient digit selection from the 3-bit estimate of 2P.
module srt_qsel
  import srt_div_pkg::*;
(
  input  logic [2:0]       est,
  output logic [DIG_W-1:0] dig_c
);

  always_comb begin
    dig_c = DIG_ZERO;
    if ($signed(est) >= EST_POS_MIN) begin
      dig_c = DIG_POS;
    end else if ($signed(est) <= EST_NEG_MAX) begin
      dig_c = DIG_NEG;
    end
  end

endmodule

// File: rtl/srt_divider_seq.sv
// Multi-cycle radix-2 SRT unsigned divider with start/done handshake.
// Optional self-check output chk_err is built when SRT_DIV_CHECK_EN is defined.
module srt_divider_seq
  import srt_div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
`ifdef SRT_DIV_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  localparam int unsigned PW = WIDTH + 2;
  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, d_q, d_d, x_q, x_d;
  logic [WIDTH-1:0]   qp_q, qp_d, qn_q, qn_d, q_q, q_d, r_q, r_d;
  logic [PW-1:0]      p_q, p_d;
  logic [CW-1:0]      k_q, k_d, s_q, s_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic [CW-1:0]      s_c;
  logic [AW-1:0]      norm_c;
  logic [PW-1:0]      two_p_c, d_ext_c, p_iter_c, p_fix_c;
  logic [WIDTH-1:0]   qp_iter_c, qn_iter_c, q_fix_c, r_fix_c;
  logic [DIG_W-1:0]   dig_c;

  // The dividend is pre-shifted by the divisor's normalisation so the
  // final partial remainder is 2^s * (a - Q*b) and Q is the integer quotient.
  assign s_c     = CW'(lzc32(32'(b_q) << (32 - WIDTH)));
  assign norm_c  = AW'(a_q) << s_c;
  assign two_p_c = PW'({p_q, x_q[WIDTH-1]});

  srt_qsel u_qsel (
    .est   (two_p_c[PW-1:PW-3]),
    .dig_c (dig_c)
  );

  // One SRT step plus the sign correction used on the last step
  always_comb begin
    d_ext_c  = PW'(d_q);
    p_iter_c = two_p_c;
    if (dig_c == DIG_POS) begin
      p_iter_c = two_p_c - d_ext_c;
    end else if (dig_c == DIG_NEG) begin
      p_iter_c = two_p_c + d_ext_c;
    end
    qp_iter_c = {qp_q[WIDTH-2:0], dig_c == DIG_POS};
    qn_iter_c = {qn_q[WIDTH-2:0], dig_c == DIG_NEG};
    q_fix_c   = qp_iter_c - qn_iter_c;
    p_fix_c   = p_iter_c;
    if (p_iter_c[PW-1]) begin
      p_fix_c = p_iter_c + d_ext_c;
      q_fix_c = q_fix_c - WIDTH'(1);
    end
    r_fix_c = WIDTH'(p_fix_c >> s_q);
  end

  // Correction is applied on the last iteration edge so done follows directly
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    x_d     = x_q;
    p_d     = p_q;
    qp_d    = qp_q;
    qn_d    = qn_q;
    k_d     = k_q;
    s_d     = s_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (b_q == '0) begin
          q_d     = '1;
          r_d     = a_q;
          dbz_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          d_d     = WIDTH'(b_q << s_c);
          p_d     = PW'(norm_c[AW-1:WIDTH]);
          x_d     = norm_c[WIDTH-1:0];
          qp_d    = '0;
          qn_d    = '0;
          k_d     = CW'(WIDTH - 1);
          s_d     = s_c;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        p_d  = p_iter_c;
        x_d  = x_q << 1;
        qp_d = qp_iter_c;
        qn_d = qn_iter_c;
        k_d  = k_q - CW'(1);
        if (k_q == '0) begin
          q_d     = q_fix_c;
          r_d     = r_fix_c;
          dbz_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_LOAD) || (state_d == ST_ITER);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      x_q     <= '0;
      p_q     <= '0;
      qp_q    <= '0;
      qn_q    <= '0;
      k_q     <= '0;
      s_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      x_q     <= x_d;
      p_q     <= p_d;
      qp_q    <= qp_d;
      qn_q    <= qn_d;
      k_q     <= k_d;
      s_q     <= s_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;

`ifdef SRT_DIV_CHECK_EN
  logic chk_err_q, chk_err_d;

  // Sticky comparison against the behavioural result while in DONE
  always_comb begin
    chk_err_d = chk_err_q;
    if ((state_q == ST_DONE) && !dbz_q &&
        ((q_q != a_q / b_q) || (r_q != a_q % b_q))) begin
      chk_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) chk_err_q <= 1'b0;
    else     chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_srt_divider_seq.sv
// Self-checking bench for srt_divider_seq at WIDTH=8 and WIDTH=16 against a
// plain-arithmetic reference model; also watches chk_err when SRT_DIV_CHECK_EN is set.
module tb_srt_divider_seq;

  logic clk = 1'b0;
  logic rst;
  logic start8, start16;
  logic [7:0]  a8, b8, q8, r8;
  logic [15:0] a16, b16, q16, r16;
  logic busy8, done8, dbz8, busy16, done16, dbz16;
`ifdef SRT_DIV_CHECK_EN
  logic chk8, chk16;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  srt_divider_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .q(q8), .r(r8), .dbz(dbz8)
`ifdef SRT_DIV_CHECK_EN
    , .chk_err(chk8)
`endif
  );

  srt_divider_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .q(q16), .r(r16), .dbz(dbz16)
`ifdef SRT_DIV_CHECK_EN
    , .chk_err(chk16)
`endif
  );

  // Reference: integer division, all-ones/a on zero divisor, fixed latency
  function automatic void ref_div(input int w, input longint ra, input longint rb,
                                  output longint eq, output longint er,
                                  output logic edbz, output int elat);
    if (rb == 0) begin
      eq = (longint'(1) << w) - 1; er = ra; edbz = 1'b1; elat = 2;
    end else begin
      eq = ra / rb; er = ra % rb; edbz = 1'b0; elat = w + 2;
    end
  endfunction

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb,
                     output logic [7:0] oq, output logic [7:0] orr, output logic odbz,
                     output int lat, output logic obusy1, output logic obusy_done);
    int cyc;
    @(negedge clk);
    a8 = ta; b8 = tb; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    obusy1 = busy8;
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    lat = (done8 === 1'b1) ? cyc : -1;
    oq = q8; orr = r8; odbz = dbz8; obusy_done = busy8;
  endtask

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb,
                      output logic [15:0] oq, output logic [15:0] orr, output logic odbz,
                      output int lat);
    int cyc;
    @(negedge clk);
    a16 = ta; b16 = tb; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    cyc = 1;
    while (done16 !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    lat = (done16 === 1'b1) ? cyc : -1;
    oq = q16; orr = r16; odbz = dbz16;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy8, done8, dbz8, q8, r8} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset8 busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0", busy8, done8, dbz8, q8, r8);
    end
    tests_run++;
    if ({busy16, done16, dbz16, q16, r16} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset16 busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0", busy16, done16, dbz16, q16, r16);
    end
    rst = 1'b0;
  endtask

  int unsigned da8[14] = '{25, 128, 255, 0, 114, 77, 25, 255, 255, 1, 128, 255, 127, 0};
  int unsigned db8[14] = '{5,  33,  52,  1, 19,  0,  6,  1,   255, 255, 128, 128, 128, 0};

  task automatic test_directed8();
    logic [7:0] gq, gr; logic gdbz, gb1, gbd; int glat;
    longint eq, er; logic edbz; int elat;
    for (int i = 0; i < 14; i++) begin
      op8(8'(da8[i]), 8'(db8[i]), gq, gr, gdbz, glat, gb1, gbd);
      ref_div(8, longint'(da8[i]), longint'(db8[i]), eq, er, edbz, elat);
      tests_run++;
      if (gq !== 8'(eq) || gr !== 8'(er) || gdbz !== edbz) begin
        tests_failed++;
        $display("FAIL dir8 %0d/%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                 da8[i], db8[i], gq, gr, gdbz, eq, er, edbz);
      end
      tests_run++;
      if (glat !== elat || gb1 !== 1'b1 || gbd !== 1'b0) begin
        tests_failed++;
        $display("FAIL timing8 %0d/%0d got lat=%0d busy1=%b busy@done=%b want lat=%0d busy1=1 busy@done=0",
                 da8[i], db8[i], glat, gb1, gbd, elat);
      end
    end
  endtask

  int unsigned da16[5] = '{65535, 40000, 65535, 1, 32768};
  int unsigned db16[5] = '{255,   7,     1,     65535, 0};

  task automatic test_directed16();
    logic [15:0] gq, gr; logic gdbz; int glat;
    longint eq, er; logic edbz; int elat;
    for (int i = 0; i < 5; i++) begin
      op16(16'(da16[i]), 16'(db16[i]), gq, gr, gdbz, glat);
      ref_div(16, longint'(da16[i]), longint'(db16[i]), eq, er, edbz, elat);
      tests_run++;
      if (gq !== 16'(eq) || gr !== 16'(er) || gdbz !== edbz || glat !== elat) begin
        tests_failed++;
        $display("FAIL dir16 %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d dbz=%b lat=%0d",
                 da16[i], db16[i], gq, gr, gdbz, glat, eq, er, edbz, elat);
      end
    end
  endtask

  task automatic test_ignore_start();
    int cyc, dones, done_cyc;
    logic [7:0] fq, fr;
    dones = 0; done_cyc = -1; fq = '0; fr = '0;
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      cyc++;
      if (done8 === 1'b1) begin
        dones++;
        if (done_cyc < 0) begin done_cyc = cyc; fq = q8; fr = r8; end
      end
      if (cyc == 3 || cyc == 5) begin
        start8 = 1'b1; a8 = 8'd9; b8 = 8'd2;
      end else begin
        start8 = 1'b0;
      end
    end
    tests_run++;
    if (dones !== 1 || done_cyc !== 10) begin
      tests_failed++;
      $display("FAIL ignore_start got dones=%0d at cycle %0d want 1 at cycle 10", dones, done_cyc);
    end
    tests_run++;
    if (fq !== 8'd28 || fr !== 8'd4 || q8 !== 8'd28 || r8 !== 8'd4) begin
      tests_failed++;
      $display("FAIL ignore_result got q=%0d r=%0d held q=%0d r=%0d want 28/4", fq, fr, q8, r8);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    logic [7:0] gq, gr; logic gdbz, gb1, gbd; int glat;
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({busy8, done8, dbz8, q8, r8} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_mid busy=%b done=%b dbz=%b q=%0d r=%0d want all 0", busy8, done8, dbz8, q8, r8);
    end
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8 === 1'b1) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_done got %0d done pulses want 0", dones);
    end
    op8(8'd200, 8'd3, gq, gr, gdbz, glat, gb1, gbd);
    tests_run++;
    if (gq !== 8'd66 || gr !== 8'd2 || gdbz !== 1'b0 || glat !== 10) begin
      tests_failed++;
      $display("FAIL after_reset got q=%0d r=%0d dbz=%b lat=%0d want 66 2 0 10", gq, gr, gdbz, glat);
    end
  endtask

  task automatic test_random();
    logic [7:0] gq8, gr8; logic [15:0] gq16, gr16;
    logic gdbz, gb1, gbd; int glat;
    longint eq, er; logic edbz; int elat;
    logic [15:0] ra, rb;
    for (int i = 0; i < 1200; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 16'($urandom_range(1, 3));
        default: rb = 16'($urandom);
      endcase
      op8(ra[7:0], rb[7:0], gq8, gr8, gdbz, glat, gb1, gbd);
      ref_div(8, longint'(ra[7:0]), longint'(rb[7:0]), eq, er, edbz, elat);
      tests_run++;
      if (gq8 !== 8'(eq) || gr8 !== 8'(er) || gdbz !== edbz || glat !== elat) begin
        tests_failed++;
        $display("FAIL rand8 %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d dbz=%b lat=%0d",
                 ra[7:0], rb[7:0], gq8, gr8, gdbz, glat, eq, er, edbz, elat);
      end
      op16(ra, rb, gq16, gr16, gdbz, glat);
      ref_div(16, longint'(ra), longint'(rb), eq, er, edbz, elat);
      tests_run++;
      if (gq16 !== 16'(eq) || gr16 !== 16'(er) || gdbz !== edbz || glat !== elat) begin
        tests_failed++;
        $display("FAIL rand16 %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d dbz=%b lat=%0d",
                 ra, rb, gq16, gr16, gdbz, glat, eq, er, edbz, elat);
      end
    end
`ifdef SRT_DIV_CHECK_EN
    tests_run++;
    if (chk8 !== 1'b0 || chk16 !== 1'b0) begin
      tests_failed++;
      $display("FAIL chk_err got chk8=%b chk16=%b want 0 0", chk8, chk16);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    test_reset();
    test_directed8();
    test_directed16();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
